stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core.sv | 196 +++++++++++++++++++
 tb/tb_stopwatch_core.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: two debounced active-low keys drive an IDLE/RUN/PAUSE
// controller, a prescaler divides CLOCK_50 down to one count per second, and a
// four-digit BCD counter holds the elapsed time (wraps 59:59 -> 00:00).
module stopwatch_core #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_START_N,
    input  logic       KEY_CLEAR_N,
    output logic [3:0] SEC_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] MIN_TENS,
    output logic       RUNNING,
    output logic       TICK_1HZ
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Key bit 0 is start, bit 1 is clear.
    logic [1:0]          raw_s;
    logic [1:0]          sync1_q;
    logic [1:0]          sync2_q;
    logic [1:0]          lvl_q;
    logic [1:0]          lvl_d;
    logic [1:0]          lvl_dly_q;
    logic [1:0][DW-1:0]  cnt_q;
    logic [1:0][DW-1:0]  cnt_d;
    logic [1:0]          press_q;

    state_t              state_q;
    state_t              state_d;
    logic [PW-1:0]       pres_q;
    logic [PW-1:0]       pres_d;
    logic [15:0]         time_q;
    logic [15:0]         time_d;
    logic                tick_q;
    logic                tick_d;
    logic                running_q;

    // Advance MM:SS by one second with BCD carries; out-of-range digits are
    // forced back into range so the display can never show a non-BCD value.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] so;
        logic [3:0] st;
        logic [3:0] mo;
        logic [3:0] mt;
        so = t[3:0];
        st = t[7:4];
        mo = t[11:8];
        mt = t[15:12];
        if (so >= 4'd9) begin
            so = 4'd0;
            if (st >= 4'd5) begin
                st = 4'd0;
                if (mo >= 4'd9) begin
                    mo = 4'd0;
                    if (mt >= 4'd5) begin
                        mt = 4'd0;
                    end else begin
                        mt = mt + 4'd1;
                    end
                end else begin
                    mo = mo + 4'd1;
                end
            end else begin
                st = st + 4'd1;
            end
        end else begin
            so = so + 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    assign raw_s = {KEY_CLEAR_N, KEY_START_N};

    // Synchronize keys, hold debounced levels and turn each 1->0 level change into a one-cycle press.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            lvl_q     <= 2'b11;
            lvl_dly_q <= 2'b11;
            cnt_q     <= '0;
            press_q   <= 2'b00;
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            cnt_q     <= cnt_d;
            press_q   <= lvl_dly_q & ~lvl_q;
        end
    end

    // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != lvl_q[k]) begin
                if (cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[k] = sync2_q[k];
                    cnt_d[k] = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + DW'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
    end

    // Controller state, prescaler, time digits and the output registers.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            pres_q    <= '0;
            time_q    <= 16'h0000;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pres_q    <= pres_d;
            time_q    <= time_d;
            tick_q    <= tick_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    // Next state: clear dominates start; time advances only on the last prescaler count in RUN.
    always_comb begin
        state_d = state_q;
        pres_d  = pres_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        if (press_q[1]) begin
            state_d = ST_IDLE;
            pres_d  = '0;
            time_d  = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_q[0]) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (press_q[0]) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                    if (pres_q == PW'(CLK_HZ - 1)) begin
                        pres_d = '0;
                        time_d = bcd_inc(time_q);
                        tick_d = 1'b1;
                    end else begin
                        pres_d = pres_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (press_q[0]) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pres_d  = '0;
                    time_d  = 16'h0000;
                end
            endcase
        end
    end

    assign SEC_ONES = time_q[3:0];
    assign SEC_TENS = time_q[7:4];
    assign MIN_ONES = time_q[11:8];
    assign MIN_TENS = time_q[15:12];
    assign RUNNING  = running_q;
    assign TICK_1HZ = tick_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core with CLK_HZ=10, DEBOUNCE_CYCLES=4. Each scenario
// queues the ticks it expects (cycle number and MM:SS digits); a monitor pops
// and compares them whenever TICK_1HZ is seen.
module tb_stopwatch_core;

    logic       CLOCK_50;
    logic       RESET_N;
    logic       KEY_START_N;
    logic       KEY_CLEAR_N;
    logic [3:0] SEC_ONES;
    logic [3:0] SEC_TENS;
    logic [3:0] MIN_ONES;
    logic [3:0] MIN_TENS;
    logic       RUNNING;
    logic       TICK_1HZ;
    logic [15:0] digits_s;

    typedef struct {
        int          cyc;
        logic [15:0] t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    stopwatch_core #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .KEY_START_N (KEY_START_N),
        .KEY_CLEAR_N (KEY_CLEAR_N),
        .SEC_ONES    (SEC_ONES),
        .SEC_TENS    (SEC_TENS),
        .MIN_ONES    (MIN_ONES),
        .MIN_TENS    (MIN_TENS),
        .RUNNING     (RUNNING),
        .TICK_1HZ    (TICK_1HZ)
    );

    assign digits_s = {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Scoreboard monitor: every observed tick must match the oldest expected one.
    always @(negedge CLOCK_50) begin
        if (TICK_1HZ === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick: tick at cycle %0d digits %h, required no tick", cyc, digits_s);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e.cyc || digits_s !== mon_e.t) begin
                    n_fail++;
                    $display("FAIL tick_check: tick at cycle %0d digits %h, required cycle %0d digits %h",
                             cyc, digits_s, mon_e.cyc, mon_e.t);
                end
            end
        end
    end

    function automatic logic [15:0] bcd_of(input int secs);
        int m;
        int s;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push_exp(input int c, input int secs);
        exp_t ev;
        ev.cyc = c;
        ev.t   = bcd_of(secs);
        exp_q.push_back(ev);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input logic start_lvl);
        exp_q.delete();
        KEY_START_N = start_lvl;
        KEY_CLEAR_N = 1'b1;
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK_50);
            n_tests++;
            if (digits_s !== 16'h0000 || RUNNING !== 1'b0 || TICK_1HZ !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: digits %h running %b tick %b, required 0000 0 0", digits_s, RUNNING, TICK_1HZ);
            end
        end
    endtask

    task automatic test_start();
        int c;
        do_reset(1'b1);
        c = cyc;
        KEY_START_N = 1'b0;
        push_exp(c + 18, 1);
        wait_cyc(c + 7);
        n_tests++;
        if (RUNNING !== 1'b0) begin
            n_fail++;
            $display("FAIL start_early: running %b, required 0", RUNNING);
        end
        wait_cyc(c + 8);
        n_tests++;
        if (RUNNING !== 1'b1) begin
            n_fail++;
            $display("FAIL start_rise: running %b, required 1", RUNNING);
        end
        wait_cyc(c + 10);
        KEY_START_N = 1'b1;
        wait_cyc(c + 19);
        n_tests++;
        if (exp_q.size() != 0 || SEC_ONES !== 4'd1 || RUNNING !== 1'b1) begin
            n_fail++;
            $display("FAIL start_first_tick: pending %0d sec_ones %0d running %b, required 0 1 1", exp_q.size(), SEC_ONES, RUNNING);
        end
    endtask

    task automatic test_glitch();
        int   c;
        logic seen;
        do_reset(1'b1);
        c = cyc;
        seen = 1'b0;
        KEY_START_N = 1'b0;
        wait_cyc(c + 3);
        KEY_START_N = 1'b1;
        wait_cyc(c + 4);
        KEY_START_N = 1'b0;
        wait_cyc(c + 7);
        KEY_START_N = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (RUNNING !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ignored: running seen %b, required 0", seen);
        end
    endtask

    task automatic test_pause();
        int c;
        int p;
        do_reset(1'b1);
        c = cyc;
        KEY_START_N = 1'b0;
        push_exp(c + 18, 1);
        wait_cyc(c + 6);
        KEY_START_N = 1'b1;
        wait_cyc(c + 17);
        KEY_START_N = 1'b0;
        wait_cyc(c + 23);
        KEY_START_N = 1'b1;
        wait_cyc(c + 24);
        n_tests++;
        if (RUNNING !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_before: running %b, required 1", RUNNING);
        end
        wait_cyc(c + 25);
        n_tests++;
        if (RUNNING !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_enter: running %b, required 0", RUNNING);
        end
        wait_cyc(c + 120);
        n_tests++;
        if (digits_s !== 16'h0001) begin
            n_fail++;
            $display("FAIL pause_hold: digits %h, required 0001", digits_s);
        end
        p = c + 125;
        wait_cyc(p);
        KEY_START_N = 1'b0;
        push_exp(p + 11, 2);
        wait_cyc(p + 6);
        KEY_START_N = 1'b1;
        wait_cyc(p + 8);
        n_tests++;
        if (RUNNING !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_rise: running %b, required 1", RUNNING);
        end
        wait_cyc(p + 12);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL resume_tick: pending %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_held_after_reset();
        int r;
        do_reset(1'b0);
        r = cyc;
        push_exp(r + 18, 1);
        wait_cyc(r + 7);
        n_tests++;
        if (RUNNING !== 1'b0) begin
            n_fail++;
            $display("FAIL held_early: running %b, required 0", RUNNING);
        end
        wait_cyc(r + 8);
        n_tests++;
        if (RUNNING !== 1'b1) begin
            n_fail++;
            $display("FAIL held_rise: running %b, required 1", RUNNING);
        end
        wait_cyc(r + 10);
        KEY_START_N = 1'b1;
        wait_cyc(r + 19);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_tick: pending %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_clear_priority();
        int c;
        int t;
        do_reset(1'b1);
        c = cyc;
        KEY_START_N = 1'b0;
        for (int k = 0; k < 83; k++) push_exp(c + 18 + 10 * k, k + 1);
        wait_cyc(c + 6);
        KEY_START_N = 1'b1;
        t = c + 18 + 820;
        wait_cyc(t);
        KEY_START_N = 1'b0;
        KEY_CLEAR_N = 1'b0;
        wait_cyc(t + 1);
        n_tests++;
        if (digits_s !== 16'h0123) begin
            n_fail++;
            $display("FAIL clear_at_0123: digits %h, required 0123", digits_s);
        end
        wait_cyc(t + 6);
        KEY_START_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        wait_cyc(t + 7);
        n_tests++;
        if (RUNNING !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_before: running %b, required 1", RUNNING);
        end
        wait_cyc(t + 8);
        n_tests++;
        if (RUNNING !== 1'b0 || digits_s !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear_priority: running %b digits %h, required 0 0000", RUNNING, digits_s);
        end
        wait_cyc(t + 40);
        n_tests++;
        if (RUNNING !== 1'b0 || digits_s !== 16'h0000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear_idle_hold: running %b digits %h pending %0d, required 0 0000 0", RUNNING, digits_s, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int c;
        do_reset(1'b1);
        c = cyc;
        KEY_START_N = 1'b0;
        for (int k = 0; k < 3600; k++) push_exp(c + 18 + 10 * k, (k + 1) % 3600);
        wait_cyc(c + 6);
        KEY_START_N = 1'b1;
        wait_cyc(c + 18 + 35980 + 1);
        n_tests++;
        if (digits_s !== 16'h5959) begin
            n_fail++;
            $display("FAIL wrap_5959: digits %h, required 5959", digits_s);
        end
        wait_cyc(c + 18 + 35990 + 1);
        n_tests++;
        if (digits_s !== 16'h0000 || RUNNING !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_0000: digits %h running %b pending %0d, required 0000 1 0", digits_s, RUNNING, exp_q.size());
        end
    endtask

    initial begin
        RESET_N     = 1'b0;
        KEY_START_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        test_reset();
        test_start();
        test_glitch();
        test_pause();
        test_held_after_reset();
        test_clear_priority();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
